// File: rtl/mvm.sv
// Matrix-vector multiply engine: 8 elements per word, NUM_OLANES parallel dot-product lanes.
// Define MVM_ACC_SAT_EN to make the accumulators saturate instead of wrapping.
module mvm #(
    parameter int IWIDTH        = 8,
    parameter int OWIDTH        = 32,
    parameter int VEC_MEM_DEPTH = 256,
    parameter int MAT_MEM_DEPTH = 512,
    parameter int NUM_OLANES    = 8,
    localparam int VEC_ADDRW    = $clog2(VEC_MEM_DEPTH),
    localparam int MAT_ADDRW    = $clog2(MAT_MEM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*IWIDTH-1:0]      i_vec_wdata,
    input  logic [VEC_ADDRW-1:0]     i_vec_waddr,
    input  logic                     i_vec_wen,
    input  logic [8*IWIDTH-1:0]      i_mat_wdata,
    input  logic [MAT_ADDRW-1:0]     i_mat_waddr,
    input  logic [NUM_OLANES-1:0]    i_mat_wen,
    input  logic                     i_start,
    input  logic [VEC_ADDRW-1:0]     i_vec_start_addr,
    input  logic [VEC_ADDRW:0]       i_vec_num_words,
    input  logic [MAT_ADDRW-1:0]     i_mat_start_addr,
    input  logic [MAT_ADDRW:0]       i_mat_num_rows_per_olane,
    output logic signed [OWIDTH-1:0] o_result [NUM_OLANES],
    output logic                     o_busy,
    output logic                     o_valid
);
    localparam int NE = 8;
    localparam int PW = 2 * IWIDTH;
    localparam int TW = PW + 3;

    typedef enum logic [1:0] {StIdle, StCompute, StDrain} state_t;

    state_t               state;
    logic [VEC_ADDRW:0]   num_words, w_cnt;
    logic [MAT_ADDRW:0]   num_rows, g_cnt;
    logic [VEC_ADDRW-1:0] vec_start, vec_addr;
    logic [MAT_ADDRW-1:0] mat_addr;
    logic                 issue, first0, last_word0, last_grp0;

    logic [8*IWIDTH-1:0] vec_mem [VEC_MEM_DEPTH];
    logic [8*IWIDTH-1:0] mat_mem [NUM_OLANES][MAT_MEM_DEPTH];
    logic [8*IWIDTH-1:0] vec_rd;
    logic [8*IWIDTH-1:0] mat_rd [NUM_OLANES];

    logic v1, v2, v3, f1, f2, f3, lw1, lw2, lw3, lg1, lg2, lg3;
    logic done4, done_last4, last_out;
    logic signed [PW-1:0]     prod_q   [NUM_OLANES][NE];
    logic signed [TW-1:0]     tree_q   [NUM_OLANES];
    logic signed [TW-1:0]     tree_sum [NUM_OLANES];
    logic signed [OWIDTH-1:0] acc_q    [NUM_OLANES];
    logic signed [OWIDTH-1:0] acc_next [NUM_OLANES];

    assign issue      = (state == StCompute);
    assign first0     = (w_cnt == '0);
    assign last_word0 = (w_cnt == num_words - (VEC_ADDRW+1)'(1));
    assign last_grp0  = last_word0 && (g_cnt == num_rows - (MAT_ADDRW+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            o_busy    <= 1'b0;
            num_words <= '0;
            num_rows  <= '0;
            w_cnt     <= '0;
            g_cnt     <= '0;
            vec_start <= '0;
            vec_addr  <= '0;
            mat_addr  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_start && i_vec_num_words != '0 && i_mat_num_rows_per_olane != '0) begin
                        num_words <= i_vec_num_words;
                        num_rows  <= i_mat_num_rows_per_olane;
                        vec_start <= i_vec_start_addr;
                        vec_addr  <= i_vec_start_addr;
                        mat_addr  <= i_mat_start_addr;
                        w_cnt     <= '0;
                        g_cnt     <= '0;
                        o_busy    <= 1'b1;
                        state     <= StCompute;
                    end
                end
                StCompute: begin
                    // Row groups are packed back to back, so the matrix address just counts up.
                    mat_addr <= mat_addr + MAT_ADDRW'(1);
                    if (last_word0) begin
                        w_cnt    <= '0;
                        vec_addr <= vec_start;
                        if (last_grp0) state <= StDrain;
                        else g_cnt <= g_cnt + (MAT_ADDRW+1)'(1);
                    end else begin
                        w_cnt    <= w_cnt + (VEC_ADDRW+1)'(1);
                        vec_addr <= vec_addr + VEC_ADDRW'(1);
                    end
                end
                StDrain: begin
                    if (o_valid && last_out) begin
                        state  <= StIdle;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Memories are never reset; reads see pre-write data on an address collision.
    always_ff @(posedge clk) begin
        if (i_vec_wen) vec_mem[i_vec_waddr] <= i_vec_wdata;
        vec_rd <= vec_mem[vec_addr];
        for (int l = 0; l < NUM_OLANES; l++) begin
            if (i_mat_wen[l]) mat_mem[l][i_mat_waddr] <= i_mat_wdata;
            mat_rd[l] <= mat_mem[l][mat_addr];
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_OLANES; l++) begin
            logic signed [OWIDTH:0] sum_ext;
            tree_sum[l] = '0;
            for (int e = 0; e < NE; e++) tree_sum[l] = tree_sum[l] + TW'(prod_q[l][e]);
            sum_ext = (f3 ? '0 : {acc_q[l][OWIDTH-1], acc_q[l]}) + (OWIDTH+1)'(tree_q[l]);
            acc_next[l] = sum_ext[OWIDTH-1:0];
`ifdef MVM_ACC_SAT_EN
            if (sum_ext[OWIDTH] != sum_ext[OWIDTH-1])
                acc_next[l] = sum_ext[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                              : {1'b0, {(OWIDTH-1){1'b1}}};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3, f1, f2, f3, lw1, lw2, lw3, lg1, lg2, lg3} <= '0;
            {done4, done_last4, o_valid, last_out} <= '0;
            for (int l = 0; l < NUM_OLANES; l++) begin
                for (int e = 0; e < NE; e++) prod_q[l][e] <= '0;
                tree_q[l]   <= '0;
                acc_q[l]    <= '0;
                o_result[l] <= '0;
            end
        end else begin
            {v1, f1, lw1, lg1} <= {issue, first0, last_word0, last_grp0};
            {v2, f2, lw2, lg2} <= {v1, f1, lw1, lg1};
            {v3, f3, lw3, lg3} <= {v2, f2, lw2, lg2};
            done4      <= v3 && lw3;
            done_last4 <= v3 && lg3;
            o_valid    <= done4;
            last_out   <= done_last4;
            for (int l = 0; l < NUM_OLANES; l++) begin
                for (int e = 0; e < NE; e++) begin
                    logic signed [IWIDTH-1:0] a, b;
                    a = vec_rd[e*IWIDTH +: IWIDTH];
                    b = mat_rd[l][e*IWIDTH +: IWIDTH];
                    prod_q[l][e] <= PW'(a) * PW'(b);
                end
                tree_q[l] <= tree_sum[l];
                if (v3) acc_q[l] <= acc_next[l];
                if (done4) o_result[l] <= acc_q[l];
            end
        end
    end
endmodule

// File: tb/tb_mvm.sv
// Directed bench for mvm: timing of o_valid/o_busy and lane results against a dot-product model.
module tb_mvm;
    logic               clk = 1'b0;
    logic               rst;
    logic [63:0]        vec_wdata, mat_wdata;
    logic [7:0]         vec_waddr;
    logic               vec_wen;
    logic [8:0]         mat_waddr;
    logic [7:0]         mat_wen;
    logic               start;
    logic [7:0]         vsa;
    logic [8:0]         vnw;
    logic [8:0]         msa;
    logic [9:0]         mnr;
    logic signed [31:0] result [8];
    logic               busy, valid;

    mvm dut (
        .clk(clk), .rst(rst),
        .i_vec_wdata(vec_wdata), .i_vec_waddr(vec_waddr), .i_vec_wen(vec_wen),
        .i_mat_wdata(mat_wdata), .i_mat_waddr(mat_waddr), .i_mat_wen(mat_wen),
        .i_start(start), .i_vec_start_addr(vsa), .i_vec_num_words(vnw),
        .i_mat_start_addr(msa), .i_mat_num_rows_per_olane(mnr),
        .o_result(result), .o_busy(busy), .o_valid(valid)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    logic [63:0]        vmod [256];
    logic [63:0]        mmod [8][512];
    int                 n_pulse, drop_cyc;
    logic               busy_after_start;
    int                 pulse_at [8];
    logic signed [31:0] res_cap [8][8];

    function automatic logic signed [31:0] golden(int l, int g, int vs, int ms, int w_n);
        logic signed [31:0] s;
        logic [63:0] tv, tm;
        int a, b;
        s = 0;
        for (int w = 0; w < w_n; w++) begin
            tv = vmod[(vs + w) % 256];
            tm = mmod[l][(ms + g * w_n + w) % 512];
            for (int e = 0; e < 8; e++) begin
                a = $signed(tv[e*8 +: 8]);
                b = $signed(tm[e*8 +: 8]);
                s = s + 32'(a * b);
            end
        end
        return s;
    endfunction

    task automatic wr_vec(input int a, input logic [63:0] d);
        @(negedge clk);
        vec_waddr = 8'(a); vec_wdata = d; vec_wen = 1'b1;
        @(negedge clk);
        vec_wen = 1'b0;
        vmod[a % 256] = d;
    endtask

    task automatic wr_mat(input int l, input int a, input logic [63:0] d);
        @(negedge clk);
        mat_waddr = 9'(a); mat_wdata = d; mat_wen = 8'(1 << l);
        @(negedge clk);
        mat_wen = '0;
        mmod[l][a % 512] = d;
    endtask

    task automatic fill(input int vs, input int ms, input int w_n, input int r_n);
        for (int w = 0; w < w_n; w++) wr_vec((vs + w) % 256, {$urandom, $urandom});
        for (int l = 0; l < 8; l++)
            for (int i = 0; i < w_n * r_n; i++) wr_mat(l, (ms + i) % 512, {$urandom, $urandom});
    endtask

    // Issue one start and record every o_valid pulse (edge index after the start edge).
    task automatic do_run(input int w_n, input int r_n, input int vs, input int ms,
                          input int inj_cyc);
        n_pulse = 0;
        drop_cyc = 0;
        @(negedge clk);
        vsa = 8'(vs); vnw = 9'(w_n); msa = 9'(ms); mnr = 10'(r_n); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_after_start = busy;
        for (int cyc = 1; cyc <= w_n * r_n + 20; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == inj_cyc) begin
                start = 1'b1; vnw = 9'd1; mnr = 10'd1; vsa = 8'd0; msa = 9'd0;
            end else begin
                start = 1'b0;
            end
            if (valid && n_pulse < 8) begin
                pulse_at[n_pulse] = cyc;
                for (int l = 0; l < 8; l++) res_cap[n_pulse][l] = result[l];
                n_pulse++;
            end
            if (!busy && drop_cyc == 0) drop_cyc = cyc;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", valid); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (result[l] !== 32'sd0) begin
                nfail++; $display("FAIL reset_result[%0d]: got %0d want 0", l, result[l]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        fill(10, 20, 4, 1);
        do_run(4, 1, 10, 20, 0);
        nvec++; if (busy_after_start !== 1'b1) begin nfail++; $display("FAIL single_busy: got %b want 1", busy_after_start); end
        nvec++; if (n_pulse != 1) begin nfail++; $display("FAIL single_npulse: got %0d want 1", n_pulse); end
        nvec++; if (pulse_at[0] != 8) begin nfail++; $display("FAIL single_latency: got %0d want 8", pulse_at[0]); end
        nvec++; if (drop_cyc != 9) begin nfail++; $display("FAIL single_busy_drop: got %0d want 9", drop_cyc); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (res_cap[0][l] !== golden(l, 0, 10, 20, 4)) begin
                nfail++; $display("FAIL single_lane%0d: got %0d want %0d", l, res_cap[0][l], golden(l, 0, 10, 20, 4));
            end
        end
    endtask

    task automatic test_two_groups;
        fill(40, 100, 2, 2);
        do_run(2, 2, 40, 100, 0);
        nvec++; if (n_pulse != 2) begin nfail++; $display("FAIL groups_npulse: got %0d want 2", n_pulse); end
        nvec++; if (pulse_at[0] != 6) begin nfail++; $display("FAIL groups_first: got %0d want 6", pulse_at[0]); end
        nvec++; if (pulse_at[1] != 8) begin nfail++; $display("FAIL groups_second: got %0d want 8", pulse_at[1]); end
        nvec++; if (drop_cyc != 9) begin nfail++; $display("FAIL groups_busy_drop: got %0d want 9", drop_cyc); end
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < 8; l++) begin
                nvec++;
                if (res_cap[g][l] !== golden(l, g, 40, 100, 2)) begin
                    nfail++; $display("FAIL groups_g%0d_lane%0d: got %0d want %0d", g, l, res_cap[g][l], golden(l, g, 40, 100, 2));
                end
            end
    endtask

    task automatic test_all_neg;
        wr_vec(60, 64'h8080_8080_8080_8080);
        for (int l = 0; l < 8; l++) wr_mat(l, 200, 64'h8080_8080_8080_8080);
        do_run(1, 1, 60, 200, 0);
        nvec++; if (pulse_at[0] != 5 || n_pulse != 1) begin nfail++; $display("FAIL neg_latency: got %0d/%0d want 5/1", pulse_at[0], n_pulse); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (res_cap[0][l] !== 32'sd131072) begin
                nfail++; $display("FAIL neg_lane%0d: got %0d want 131072", l, res_cap[0][l]);
            end
        end
    endtask

    task automatic test_ignore;
        fill(70, 300, 3, 1);
        do_run(3, 1, 70, 300, 2);
        nvec++; if (n_pulse != 1) begin nfail++; $display("FAIL busy_start_npulse: got %0d want 1", n_pulse); end
        nvec++; if (pulse_at[0] != 7) begin nfail++; $display("FAIL busy_start_latency: got %0d want 7", pulse_at[0]); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (res_cap[0][l] !== golden(l, 0, 70, 300, 3)) begin
                nfail++; $display("FAIL busy_start_lane%0d: got %0d want %0d", l, res_cap[0][l], golden(l, 0, 70, 300, 3));
            end
        end
        do_run(0, 1, 70, 300, 0);
        nvec++; if (busy_after_start !== 1'b0) begin nfail++; $display("FAIL w0_busy: got %b want 0", busy_after_start); end
        nvec++; if (n_pulse != 0) begin nfail++; $display("FAIL w0_npulse: got %0d want 0", n_pulse); end
        do_run(3, 0, 70, 300, 0);
        nvec++; if (n_pulse != 0 || busy_after_start !== 1'b0) begin nfail++; $display("FAIL r0_ignored: got %0d pulses busy %b want 0/0", n_pulse, busy_after_start); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (result[l] !== golden(l, 0, 70, 300, 3)) begin
                nfail++; $display("FAIL hold_lane%0d: got %0d want %0d", l, result[l], golden(l, 0, 70, 300, 3));
            end
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        fill(80, 400, 4, 2);
        @(negedge clk);
        vsa = 8'd80; vnw = 9'd4; msa = 9'd400; mnr = 10'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        nvec++; if (valid !== 1'b0) begin nfail++; $display("FAIL midrst_valid: got %b want 0", valid); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (result[l] !== 32'sd0) begin nfail++; $display("FAIL midrst_result[%0d]: got %0d want 0", l, result[l]); end
        end
        stray = 0;
        repeat (15) begin @(posedge clk); #1; if (valid || busy) stray++; end
        nvec++; if (stray != 0) begin nfail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", stray); end
        do_run(4, 2, 80, 400, 0);
        nvec++; if (n_pulse != 2 || pulse_at[0] != 8 || pulse_at[1] != 12) begin
            nfail++; $display("FAIL restart_timing: got %0d pulses at %0d,%0d want 2 at 8,12", n_pulse, pulse_at[0], pulse_at[1]);
        end
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < 8; l++) begin
                nvec++;
                if (res_cap[g][l] !== golden(l, g, 80, 400, 4)) begin
                    nfail++; $display("FAIL restart_g%0d_lane%0d: got %0d want %0d", g, l, res_cap[g][l], golden(l, g, 80, 400, 4));
                end
            end
    endtask

    task automatic test_wrap;
        fill(255, 450, 2, 1);
        do_run(2, 1, 255, 450, 0);
        nvec++; if (n_pulse != 1 || pulse_at[0] != 6) begin nfail++; $display("FAIL wrap_timing: got %0d pulses at %0d want 1 at 6", n_pulse, pulse_at[0]); end
        for (int l = 0; l < 8; l++) begin
            nvec++;
            if (res_cap[0][l] !== golden(l, 0, 255, 450, 2)) begin
                nfail++; $display("FAIL wrap_lane%0d: got %0d want %0d", l, res_cap[0][l], golden(l, 0, 255, 450, 2));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vec_wen = 1'b0; mat_wen = '0;
        vec_wdata = '0; mat_wdata = '0; vec_waddr = '0; mat_waddr = '0;
        vsa = '0; vnw = '0; msa = '0; mnr = '0;
        test_reset();
        test_single();
        test_two_groups();
        test_all_neg();
        test_ignore();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
